// File: rtl/stack_alu_seq.sv
// -----------------------------------------------------------------------------
// stack_alu_seq
//   Multi-cycle ALU sitting between the stack core's operand fetch and its
//   writeback. Logic/add/sub ops finish in one cycle. Shifts move one bit per
//   cycle. MUL/MULH use shift-add and DIV/MOD use a restoring divider, each
//   needing WIDTH+1 cycles. Handshake is valid/ready on both sides. The
//   result and flags are registered.
//
//   Optional feature macro: ALU_DIVIDE_EN
//     defined   : DIV/MOD (01110/01111) are implemented.
//     undefined : DIV/MOD decode as illegal ops (q=0, err=1, one cycle) and
//                 no divider datapath is built.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   op/a/b presented       in_ready   high only in IDLE
//   op[4:0]    operation code         a, b       operands
//   abort      cancels a BUSY op; no result is produced
//   out_valid  result valid (DONE)    out_ready  consumer takes result
//   q          result                 carry      carry / no-borrow
//   zero       q == 0                 minus1     q == all ones
//   sign       q[WIDTH-1]             err        illegal op or divide by zero
// -----------------------------------------------------------------------------
module stack_alu_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             zero,
  output logic             minus1,
  output logic             sign,
  output logic             err
);

  // The iteration counter must be able to hold WIDTH itself.
  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_ADC  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_NOT  = 5'b00110;
  localparam logic [4:0] OP_PASS = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SAR  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_MULH = 5'b01101;
`ifdef ALU_DIVIDE_EN
  localparam logic [4:0] OP_DIV  = 5'b01110;
  localparam logic [4:0] OP_MOD  = 5'b01111;
`endif

  // ---------------------------------------------------------------------------
  // State
  //   acc/aux : shifts use acc; multiply keeps {hi,lo} = {acc,aux};
  //             divide keeps remainder in acc and the quotient/dividend in aux.
  //   m_r     : multiplicand (MUL/MULH) or divisor (DIV/MOD).
  // ---------------------------------------------------------------------------
  logic [1:0]       state, state_d;
  logic [4:0]       op_r, op_d;
  logic [WIDTH-1:0] acc, acc_d;
  logic [WIDTH-1:0] aux, aux_d;
  logic [WIDTH-1:0] m_r, m_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             carry_reg, carry_reg_d;

  logic             res_load;
  logic [WIDTH-1:0] res_q;
  logic             res_c;
  logic             res_err;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     sum_add, sum_adc, sum_sub;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
  logic               last;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  assign shamt   = b[SHAMT_W-1:0];
  assign sum_add = {1'b0, a} + {1'b0, b};
  assign sum_adc = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_reg};
  // Subtract as a + ~b + 1 so bit WIDTH is the no-borrow flag.
  assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  // One shift-add step: conditionally add the multiplicand into the high
  // word, then shift the whole {carry,hi,lo} right by one.
  assign mul_sum  = {1'b0, acc} + (aux[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], aux[WIDTH-1:1]};

`ifdef ALU_DIVIDE_EN
  // One restoring-divide step: shift the next dividend bit into the
  // remainder and subtract the divisor if it fits. A zero divisor always
  // "fits", which naturally yields q=all ones and remainder=a.
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_n, quo_n;

  assign rem_sh = {acc, aux[WIDTH-1]};
  assign div_ge = (rem_sh >= {1'b0, m_r});
  assign rem_n  = div_ge ? (rem_sh[WIDTH-1:0] - m_r) : rem_sh[WIDTH-1:0];
  assign quo_n  = {aux[WIDTH-2:0], div_ge};
`endif

  assign last = (cnt == CNT_W'(1));

  function automatic logic [WIDTH-1:0] shift1(input logic [4:0] o,
                                              input logic [WIDTH-1:0] v);
    case (o)
      OP_SHL:  shift1 = v << 1;
      OP_SHR:  shift1 = v >> 1;
      default: shift1 = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d     = state;
    op_d        = op_r;
    acc_d       = acc;
    aux_d       = aux;
    m_d         = m_r;
    cnt_d       = cnt;
    carry_reg_d = carry_reg;
    res_load    = 1'b0;
    res_q       = '0;
    res_c       = 1'b0;
    res_err     = 1'b0;

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          op_d = op;
          case (op)
            OP_ADD: begin
              res_q = sum_add[WIDTH-1:0]; res_c = sum_add[WIDTH];
              carry_reg_d = sum_add[WIDTH]; res_load = 1'b1;
            end
            OP_ADC: begin
              res_q = sum_adc[WIDTH-1:0]; res_c = sum_adc[WIDTH];
              carry_reg_d = sum_adc[WIDTH]; res_load = 1'b1;
            end
            OP_SUB: begin
              res_q = sum_sub[WIDTH-1:0]; res_c = sum_sub[WIDTH];
              carry_reg_d = sum_sub[WIDTH]; res_load = 1'b1;
            end
            OP_AND:  begin res_q = a & b; res_load = 1'b1; end
            OP_OR:   begin res_q = a | b; res_load = 1'b1; end
            OP_XOR:  begin res_q = a ^ b; res_load = 1'b1; end
            OP_NOT:  begin res_q = ~a;    res_load = 1'b1; end
            OP_PASS: begin res_q = b;     res_load = 1'b1; end
            OP_SHL, OP_SHR, OP_SAR: begin
              // The accept edge already performs the first bit, so n<=1
              // completes immediately and longer shifts need n-1 more cycles.
              if (shamt <= SHAMT_W'(1)) begin
                res_q    = (shamt == '0) ? a : shift1(op, a);
                res_load = 1'b1;
              end else begin
                acc_d   = shift1(op, a);
                cnt_d   = {1'b0, shamt} - CNT_W'(1);
                state_d = S_BUSY;
              end
            end
            OP_MUL, OP_MULH: begin
              acc_d   = '0;
              aux_d   = b;
              m_d     = a;
              cnt_d   = CNT_W'(WIDTH);
              state_d = S_BUSY;
            end
`ifdef ALU_DIVIDE_EN
            OP_DIV, OP_MOD: begin
              acc_d   = '0;
              aux_d   = a;
              m_d     = b;
              cnt_d   = CNT_W'(WIDTH);
              state_d = S_BUSY;
            end
`endif
            default: begin
              res_q    = '0;
              res_err  = 1'b1;
              res_load = 1'b1;
            end
          endcase
          if (res_load) state_d = S_DONE;
        end
      end

      S_BUSY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
          case (op_r)
            OP_MUL, OP_MULH: begin
              acc_d = mul_hi_n;
              aux_d = mul_lo_n;
              res_q = (op_r == OP_MUL) ? mul_lo_n : mul_hi_n;
              res_c = (op_r == OP_MUL) ? (|mul_hi_n) : 1'b0;
            end
`ifdef ALU_DIVIDE_EN
            OP_DIV, OP_MOD: begin
              acc_d   = rem_n;
              aux_d   = quo_n;
              res_q   = (op_r == OP_DIV) ? quo_n : rem_n;
              res_err = (m_r == '0);
            end
`endif
            default: begin
              acc_d = shift1(op_r, acc);
              res_q = shift1(op_r, acc);
            end
          endcase
          if (last) begin
            res_load = 1'b1;
            state_d  = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_r      <= '0;
      acc       <= '0;
      aux       <= '0;
      m_r       <= '0;
      cnt       <= '0;
      carry_reg <= 1'b0;
      q         <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      minus1    <= 1'b0;
      sign      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      op_r      <= op_d;
      acc       <= acc_d;
      aux       <= aux_d;
      m_r       <= m_d;
      cnt       <= cnt_d;
      carry_reg <= carry_reg_d;
      if (res_load) begin
        q      <= res_q;
        carry  <= res_c;
        zero   <= (res_q == '0);
        minus1 <= (&res_q);
        sign   <= res_q[WIDTH-1];
        err    <= res_err;
      end
    end
  end

endmodule

// File: tb/tb_stack_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_stack_alu_seq
//   Directed bench for stack_alu_seq (WIDTH=16). Each issued op pushes its
//   expected result, flags and latency onto a scoreboard; the entry is popped
//   and compared when out_valid rises. Inputs change and outputs are sampled
//   1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_stack_alu_seq;

  localparam int W = 16;

  localparam logic [4:0] ADD  = 5'b00000;
  localparam logic [4:0] ADC  = 5'b00001;
  localparam logic [4:0] SUB  = 5'b00010;
  localparam logic [4:0] AND_ = 5'b00011;
  localparam logic [4:0] OR_  = 5'b00100;
  localparam logic [4:0] XOR_ = 5'b00101;
  localparam logic [4:0] NOT_ = 5'b00110;
  localparam logic [4:0] PASS = 5'b00111;
  localparam logic [4:0] SHL  = 5'b01000;
  localparam logic [4:0] SHR  = 5'b01001;
  localparam logic [4:0] SAR  = 5'b01010;
  localparam logic [4:0] MUL  = 5'b01100;
  localparam logic [4:0] MULH = 5'b01101;
  localparam logic [4:0] DIV  = 5'b01110;
  localparam logic [4:0] MOD  = 5'b01111;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         abort = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] q;
  logic         carry, zero, minus1, sign, err;

  stack_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .carry(carry), .zero(zero), .minus1(minus1), .sign(sign), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         c;
    logic         e;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic mc = 1'b0;  // model copy of the ALU's internal carry register

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compute the expected outcome, queue it, and present the op for exactly
  // one accept edge. Operands are scrambled afterwards to prove latching.
  task automatic send(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t               e;
    int                 s;
    int                 n;
    logic [31:0]        p;
    logic signed [W-1:0] sx;
    n     = int'(y[3:0]);
    sx    = x;
    e.q   = '0;
    e.c   = 1'b0;
    e.e   = 1'b0;
    e.lat = 1;
    case (o)
      ADD:  begin s = int'(x) + int'(y); e.q = W'(s); e.c = (s > 65535); mc = e.c; end
      ADC:  begin s = int'(x) + int'(y) + int'(mc); e.q = W'(s); e.c = (s > 65535); mc = e.c; end
      SUB:  begin e.q = x - y; e.c = (x >= y); mc = e.c; end
      AND_: e.q = x & y;
      OR_:  e.q = x | y;
      XOR_: e.q = x ^ y;
      NOT_: e.q = ~x;
      PASS: e.q = y;
      SHL:  begin e.q = x << n; e.lat = (n == 0) ? 1 : n; end
      SHR:  begin e.q = x >> n; e.lat = (n == 0) ? 1 : n; end
      SAR:  begin e.q = sx >>> n; e.lat = (n == 0) ? 1 : n; end
      MUL:  begin p = x * y; e.q = p[15:0]; e.c = (p[31:16] != 16'h0); e.lat = W + 1; end
      MULH: begin p = x * y; e.q = p[31:16]; e.lat = W + 1; end
`ifdef ALU_DIVIDE_EN
      DIV:  begin e.q = (y == 0) ? 16'hffff : x / y; e.e = (y == 0); e.lat = W + 1; end
      MOD:  begin e.q = (y == 0) ? x : x % y;        e.e = (y == 0); e.lat = W + 1; end
`endif
      default: begin e.q = '0; e.e = 1'b1; end
    endcase
    sb.push_back(e);
    check("in_ready before accept", in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op = 5'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  // Wait (bounded) for out_valid, compare against the scoreboard head,
  // optionally hold backpressure for 'hold' cycles, then release.
  task automatic collect(input string tag, input int hold);
    exp_t e;
    int   lat;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, " latency"}, lat, e.lat);
    check({tag, " q"}, q, e.q);
    check({tag, " carry"}, carry, e.c);
    check({tag, " zero"}, zero, (e.q == 16'h0));
    check({tag, " minus1"}, minus1, (e.q == 16'hffff));
    check({tag, " sign"}, sign, e.q[15]);
    check({tag, " err"}, err, e.e);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold out_valid"}, out_valid, 1);
      check({tag, " hold q"}, q, e.q);
      check({tag, " hold carry"}, carry, e.c);
      check({tag, " hold in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " release out_valid"}, out_valid, 0);
    check({tag, " release in_ready"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset q", q, 0);
    check("reset flags", {carry, zero, minus1, sign, err}, 0);
    reset_n = 1'b1;
    tick();

    // Single-cycle arithmetic and carry chain
    send(ADD, 16'h4444, 16'h2345); collect("add", 0);
    send(ADD, 16'hff00, 16'h0100); collect("add carry", 0);
    send(ADC, 16'h0001, 16'h0001); collect("adc", 0);
    send(ADD, 16'h7777, 16'h8888); collect("add minus1", 0);
    send(SUB, 16'h0005, 16'h0007); collect("sub borrow", 0);
    send(SUB, 16'h0009, 16'h0003); collect("sub noborrow", 0);
    send(AND_, 16'hf0f0, 16'h3c3c); collect("and", 0);
    send(OR_,  16'hf0f0, 16'h0f0e); collect("or", 0);
    send(XOR_, 16'hffff, 16'hffff); collect("xor", 0);
    send(NOT_, 16'h00ff, 16'h1234); collect("not", 0);
    send(PASS, 16'h1111, 16'h8001); collect("pass", 0);
    send(ADC, 16'h0000, 16'h0000); collect("adc carry kept", 0);

    // Iterative shifts, including n=0 and n=1
    send(SHL, 16'h0001, 16'h000f); collect("shl 15", 0);
    send(SHR, 16'h8000, 16'h0004); collect("shr 4", 0);
    send(SAR, 16'h8000, 16'h0003); collect("sar 3", 0);
    send(SAR, 16'h4000, 16'h0002); collect("sar pos", 0);
    send(SHL, 16'hbeef, 16'hfff0); collect("shl 0", 0);
    send(SHR, 16'hbeef, 16'h0001); collect("shr 1", 0);

    // Multiply
    send(MUL,  16'h0100, 16'h0100); collect("mul", 0);
    send(MULH, 16'h0100, 16'h0100); collect("mulh", 0);
    send(MUL,  16'hffff, 16'hffff); collect("mul max", 0);
    send(MULH, 16'h1234, 16'h5678); collect("mulh mix", 0);

    // Divide (illegal when the divider is not built)
    send(DIV, 16'h0064, 16'h0007); collect("div", 0);
    send(MOD, 16'h0064, 16'h0007); collect("mod", 0);
    send(DIV, 16'h1234, 16'h0000); collect("div by zero", 0);
    send(MOD, 16'h1234, 16'h0000); collect("mod by zero", 0);

    // Illegal op
    send(5'b10000, 16'h1234, 16'h5678); collect("illegal", 0);

    // Backpressure on single-cycle and iterative results
    send(XOR_, 16'h5a5a, 16'h0ff0); collect("bp xor", 5);
    send(MUL, 16'h0003, 16'h0007); collect("bp mul", 5);

    // Abort mid-MUL: no result, carry register survives
    send(ADD, 16'hffff, 16'h0001); collect("add before abort", 0);
    send(MUL, 16'h0123, 16'h0456);
    void'(sb.pop_back());
    repeat (5) begin
      tick();
      check("busy out_valid", out_valid, 0);
      check("busy in_ready", in_ready, 0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort in_ready", in_ready, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("after abort out_valid", out_valid, 0);
    end
    send(ADC, 16'h0000, 16'h0000); collect("adc after abort", 0);

    // Abort outside BUSY is ignored
    send(PASS, 16'h0000, 16'h4321);
    abort = 1'b1;
    collect("abort in done", 0);
    abort = 1'b0;

    // Reset mid-BUSY
    send(MUL, 16'h0003, 16'h0005);
    void'(sb.pop_back());
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    mc = 1'b0;
    check("rst busy out_valid", out_valid, 0);
    check("rst busy in_ready", in_ready, 1);
    check("rst busy q", q, 0);
    check("rst busy flags", {carry, zero, minus1, sign, err}, 0);
    tick();
    reset_n = 1'b1;
    tick();
    send(ADC, 16'h0001, 16'h0001); collect("adc after reset", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
